// File: rtl/scan_io_driver.sv
// scan_io_driver
//   Upstream feeder for one 8-bit user design slot. A stimulus word is taken
//   over a valid/ready handshake and shifted MSB-first through an 8-stage scan
//   register, which models chain timing. The word is then latched onto the
//   design inputs. After a settle window the design outputs are captured and
//   returned over a second valid/ready handshake. module_in changes only on
//   the latch edge, so the design never sees a partially shifted word.
//
//   Optional macro SCAN_IO_AUTO_CLK_EN: when it is defined, CLKHI and CLKLO
//   states are inserted after LATCH. Together they put one pulse on
//   module_in[0], which acts as the design clock.
//
// Ports
//   clk, rst_n             system clock (rising edge), async active-low reset
//   in_data/in_valid/in_ready       stimulus handshake
//   resp_data/resp_valid/resp_ready response handshake
//   module_in  / module_out  user design io_in / io_out
//   busy       high in any state other than IDLE
//   txn_count  completed transactions, wraps 255 -> 0
module scan_io_driver #(
  parameter int SETTLE_CYCLES = 2,   // 1..255
  parameter int WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] module_in,
  input  logic [WIDTH-1:0] module_out,
  output logic             busy,
  output logic [7:0]       txn_count
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
`ifdef SCAN_IO_AUTO_CLK_EN
    CLKHI,
    CLKLO,
`endif
    SETTLE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shreg;
  logic [2:0]       cnt;
  logic [7:0]       scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_nxt = LATCH;
`ifdef SCAN_IO_AUTO_CLK_EN
      LATCH:   state_nxt = CLKHI;
      CLKHI:   state_nxt = CLKLO;
      CLKLO:   state_nxt = SETTLE;
`else
      LATCH:   state_nxt = SETTLE;
`endif
      SETTLE:  if (scnt == SETTLE_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      shreg      <= '0;
      cnt        <= '0;
      scnt       <= '0;
      module_in  <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      txn_count  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // The word is held internally, so later changes on in_data are ignored.
          word <= in_data;
          cnt  <= '0;
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], word[3'd7 - cnt]};
          cnt   <= cnt + 3'd1;
        end
        LATCH: begin
          module_in <= shreg;
          scnt      <= '0;
        end
`ifdef SCAN_IO_AUTO_CLK_EN
        CLKHI: module_in[0] <= 1'b1;
        CLKLO: module_in[0] <= 1'b0;
`endif
        SETTLE: scnt <= scnt + 8'd1;
        CAPTURE: begin
          resp_data  <= module_out;
          resp_valid <= 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          txn_count  <= txn_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/scan_io_driver.md
Name: scan_io_driver

Overview:
- Upstream feeder for one 8-bit user design slot (io_in[7:0] / io_out[7:0] style).
- Accepts an 8-bit stimulus word over a valid/ready handshake and serialises it through an internal 8-stage scan shift register, modelling chain timing.
- Latches the word onto the design's inputs, waits a settle window, then captures the design's outputs.
- Returns the captured outputs over a second valid/ready handshake. Inputs are glitch-free: module_in changes only on the latch edge.

Parameters:
- SETTLE_CYCLES, 2, cycles between latch and capture; legal range 1..255.
- WIDTH, 8, slot I/O width; fixed at 8 for this slot type, kept for readability.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  stimulus word for the design.
- in_valid  input  1  stimulus word present.
- in_ready  output  1  driver can accept a word.
- resp_data  output  8  captured design outputs.
- resp_valid  output  1  resp_data valid.
- resp_ready  input  1  consumer accepts resp_data.
- module_in  output  8  drives the user design io_in.
- module_out  input  8  from the user design io_out.
- busy  output  1  high in any state other than IDLE.
- txn_count  output  8  completed transactions, wraps 255->0.

Behaviour:
- Reset (async, rst_n=0) puts every output in a defined state immediately:
  - state=IDLE, shift register=0, module_in=0, resp_data=0, resp_valid=0, txn_count=0, busy=0, in_ready=1.
- Reset asserted mid-transaction aborts it. No response is produced and txn_count is not incremented.
- States: IDLE, SHIFT, LATCH, SETTLE, CAPTURE, RESP.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: hold word = in_data, bit counter=0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge shifts one bit, MSB first, into shreg (shreg <= {shreg[6:0], word[7-cnt]}) and increments cnt.
  - After the 8th shift, go to LATCH.
  - module_in is unchanged throughout.
- LATCH:
  - One cycle. Edge: module_in <= shreg, which equals the accepted in_data. Settle counter=0. Go to SETTLE.
- SETTLE:
  - Counter increments each edge.
  - At the edge where counter==SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE:
  - One cycle. Edge: resp_data <= module_out, resp_valid <= 1. Go to RESP.
- RESP:
  - Hold resp_data and resp_valid stable until an edge with resp_ready=1.
  - On that edge: resp_valid <= 0, txn_count <= txn_count+1 (mod 256), go to IDLE.
  - in_ready=0 in RESP, so there is no overlap; the next word is accepted earliest one cycle after the response handshake.
- Latency: resp_valid rises on the edge 10+SETTLE_CYCLES edges after the accept edge (12 with defaults).
- module_in holds its last latched value indefinitely between transactions.
- in_valid deasserted during SHIFT..RESP is ignored. in_data changes after accept are ignored (the word is held internally).
- resp_ready high outside RESP is ignored.
- txn_count wraps from 255 to 0 without a flag.

Optional Feature:
- Macro: SCAN_IO_AUTO_CLK_EN.
- Defined:
  - Two states, CLKHI and CLKLO, are inserted between LATCH and SETTLE.
  - CLKHI edge: module_in[0] <= 1.
  - CLKLO edge: module_in[0] <= 0.
  - Bits [7:1] keep their latched values.
  - This gives the design one clock pulse on io_in[0]. Latency becomes 12+SETTLE_CYCLES.
- Undefined:
  - Neither state exists.
  - module_in[0] is simply the latched in_data[0].

Test Plan:
- Reset then idle -> module_in=0x00, resp_valid=0, in_ready=1, txn_count=0, busy=0.
- Send in_data=0xA5 with module_out tied to ~module_in, resp_ready=1 -> module_in=0xA5 from the latch edge; resp_valid 12 edges after accept with resp_data=0x5A; txn_count=1.
- Back-pressure: resp_ready=0 for 20 cycles after resp_valid -> resp_data stable, in_ready=0 and a new in_valid is not accepted; resp_ready=1 completes the handshake, then the next word is accepted.
- Reset mid-SHIFT after 4 bits of 0xFF -> all outputs return to reset values at once; txn_count=0; a following 0x3C transaction completes normally.
- 256 back-to-back transactions -> txn_count returns to 0x00; every resp_data matches its expected value.
- With SCAN_IO_AUTO_CLK_EN and in_data=0x02 -> module_in[0] sequence 0,1,0 over the latch/CLKHI/CLKLO edges; resp_valid at 14 edges after accept.
